// File: rtl/uart_pattern_gen.sv
// uart_pattern_gen
//   Trigger-driven character-stream source for the uart_tx byte interface.
//   A debounced pushbutton press or a start pulse sends a run of LEN
//   incrementing characters. Modes: ONESHOT, REPEAT (bursts separated by
//   GAP_CYCLES idle clocks), CRLF (burst followed by CR LF), and BINARY
//   (raw index values).
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high reset
//   pb         : raw active-low pushbutton (asynchronous to clk)
//   start      : synchronous trigger, same effect as a button press
//   mode       : 00 ONESHOT, 01 REPEAT, 10 CRLF, 11 BINARY
//   ready      : sink can accept a character
//   data       : character to transmit (holds while dvalid is low)
//   dvalid     : one-cycle strobe qualifying data
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse per completed burst
//   frame_cnt  : completed-burst counter, wraps
module uart_pattern_gen #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned FIRST_CHAR      = 'h41,
    parameter int unsigned LEN             = 26,
    parameter int unsigned GAP_CYCLES      = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pb,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              dvalid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_TAIL,
        S_FINISH,
        S_GAP
    } state_e;

    typedef enum logic [1:0] {
        M_ONESHOT = 2'b00,
        M_REPEAT  = 2'b01,
        M_CRLF    = 2'b10,
        M_BINARY  = 2'b11
    } mode_e;

    // Which character SEND/WAIT_ACK are handling: burst body, CR or LF.
    typedef enum logic [1:0] {
        TP_NONE,
        TP_CR,
        TP_LF
    } tail_e;

    // ------------------------------------------------------------------
    // Pushbutton synchroniser and debounce
    // ------------------------------------------------------------------
    logic            pb_meta;
    logic            pb_sync;
    logic            pb_db;
    logic            pb_db_d;
    logic [DB_W-1:0] db_cnt;
    logic            trig;

    always_ff @(posedge clk) begin
        if (reset) begin
            pb_meta <= 1'b1;
            pb_sync <= 1'b1;
            pb_db   <= 1'b1;
            pb_db_d <= 1'b1;
            db_cnt  <= '0;
        end else begin
            pb_meta <= pb;
            pb_sync <= pb_meta;
            pb_db_d <= pb_db;
            // Any return to agreement restarts the stability count.
            if (pb_sync != pb_db) begin
                if (db_cnt == DB_LAST) begin
                    pb_db  <= pb_sync;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Press = debounced falling edge (active-low button).
    assign trig = start | (pb_db_d & ~pb_db);

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    state_e             state, state_n;
    mode_e              mode_q, mode_n;
    tail_e              tail_ph, tail_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic [DATA_W-1:0]  data_n;
    logic               dvalid_n;
    logic               done_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [DATA_W-1:0]  char_val;

    always_comb begin
        char_val = '0;
        case (tail_ph)
            TP_CR:   char_val = DATA_W'(8'h0D);
            TP_LF:   char_val = DATA_W'(8'h0A);
            default: begin
                if (mode_q == M_BINARY) begin
                    char_val = DATA_W'(idx);
                end else begin
                    char_val = DATA_W'(FIRST_CHAR) + DATA_W'(idx);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mode_q    <= M_ONESHOT;
            tail_ph   <= TP_NONE;
            idx       <= '0;
            gap_cnt   <= '0;
            data      <= '0;
            dvalid    <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            tail_ph   <= tail_n;
            idx       <= idx_n;
            gap_cnt   <= gap_n;
            data      <= data_n;
            dvalid    <= dvalid_n;
            done      <= done_n;
            frame_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        tail_n   = tail_ph;
        idx_n    = idx;
        gap_n    = gap_cnt;
        data_n   = data;
        dvalid_n = 1'b0;
        done_n   = 1'b0;
        cnt_n    = frame_cnt;

        case (state)
            S_IDLE: begin
                if (trig) begin
                    mode_n  = mode_e'(mode);
                    idx_n   = '0;
                    tail_n  = TP_NONE;
                    state_n = S_SEND;
                end
            end

            S_SEND: begin
                if (ready) begin
                    dvalid_n = 1'b1;
                    data_n   = char_val;
                    state_n  = S_WAIT_ACK;
                end
            end

            S_WAIT_ACK: begin
                if (!ready) begin
                    case (tail_ph)
                        TP_NONE: begin
                            if (idx < IDX_LAST) begin
                                idx_n   = idx + IDX_W'(1);
                                state_n = S_SEND;
                            end else if (mode_q == M_CRLF) begin
                                state_n = S_TAIL;
                            end else begin
                                state_n = S_FINISH;
                            end
                        end
                        TP_CR:   state_n = S_TAIL;
                        default: state_n = S_FINISH;
                    endcase
                end
            end

            // CR and LF reuse SEND/WAIT_ACK; TAIL just advances the phase.
            S_TAIL: begin
                tail_n  = (tail_ph == TP_NONE) ? TP_CR : TP_LF;
                state_n = S_SEND;
            end

            // done/frame_cnt are registered here, so the pulse appears
            // in the cycle after FINISH (IDLE or first GAP cycle).
            S_FINISH: begin
                done_n = 1'b1;
                cnt_n  = frame_cnt + CNT_W'(1);
                tail_n = TP_NONE;
                if (mode_q == M_REPEAT && mode == M_REPEAT) begin
                    gap_n   = '0;
                    state_n = S_GAP;
                end else begin
                    state_n = S_IDLE;
                end
            end

            S_GAP: begin
                if (GAP_CYCLES == 0 || gap_cnt == GAP_LAST) begin
                    idx_n   = '0;
                    state_n = S_SEND;
                end else begin
                    gap_n = gap_cnt + GAP_W'(1);
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule
